// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment display stage.
package seg7_pkg;

  typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low gfedcba patterns; element 0 is the rightmost entry.
  localparam logic [15:0][6:0] HEX_SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG_LUT[i_hex];

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit common-anode scan driver with inter-digit blanking and frame-aligned value updates.
// Build option: define LEADING_ZERO_BLANK_EN to blank the carry digit when carry is 0.
//
// state | meaning
// SHOW  | current digit lit for CLK_DIV clocks
// GAP   | all anodes off for GAP_CYC clocks, then advance digit
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic [3:0] sum_in,
  input  logic       carry_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       load_ack,
  output logic       frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_CYC + 1);

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [GW-1:0] r_gap;
  digit_idx_t    r_digit;

  logic [3:0] r_sh_a, r_sh_b, r_sh_sum;
  logic       r_sh_carry;
  logic [3:0] r_act_a, r_act_b, r_act_sum;
  logic       r_act_carry;
  logic       r_pending;

  logic [6:0] r_seg;
  logic [3:0] r_an;
  logic       r_load_ack;
  logic       r_frame_done;

  logic       w_gap_exit;
  logic       w_frame_end;
  logic [3:0] w_nib;
  logic [6:0] w_seg;
  logic       w_blank_lz;

  assign w_gap_exit  = (r_state == GAP) && (r_gap == GW'(GAP_CYC - 1));
  assign w_frame_end = w_gap_exit && (r_digit == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SHOW;
      r_presc <= '0;
      r_gap   <= '0;
      r_digit <= '0;
    end else begin
      case (r_state)
        SHOW: begin
          if (r_presc == PW'(CLK_DIV - 1)) begin
            r_presc <= '0;
            r_state <= GAP;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        GAP: begin
          if (w_gap_exit) begin
            r_gap   <= '0;
            r_digit <= r_digit + 1'b1;
            r_state <= SHOW;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= SHOW;
      endcase
    end
  end

  // A load on the boundary edge lands in the shadow after the transfer reads it, so pending stays set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_sh_sum    <= '0;
      r_sh_carry  <= 1'b0;
      r_act_a     <= '0;
      r_act_b     <= '0;
      r_act_sum   <= '0;
      r_act_carry <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      if (w_frame_end && r_pending) begin
        r_act_a     <= r_sh_a;
        r_act_b     <= r_sh_b;
        r_act_sum   <= r_sh_sum;
        r_act_carry <= r_sh_carry;
        r_pending   <= 1'b0;
      end
      if (load) begin
        r_sh_a     <= a_in;
        r_sh_b     <= b_in;
        r_sh_sum   <= sum_in;
        r_sh_carry <= carry_in;
        r_pending  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nib = r_act_sum;
    case (r_digit)
      2'd0: w_nib = r_act_sum;
      2'd1: w_nib = {3'b000, r_act_carry};
      2'd2: w_nib = r_act_b;
      2'd3: w_nib = r_act_a;
      default: w_nib = r_act_sum;
    endcase
  end

  hex_to_seg7 u_dec (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank_lz = (r_digit == 2'd1) && !r_act_carry;
`else
  assign w_blank_lz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an         <= AN_OFF;
      r_seg        <= SEG_BLANK;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if ((r_state == GAP) || w_blank_lz) begin
        r_an  <= AN_OFF;
        r_seg <= SEG_BLANK;
      end else begin
        r_an  <= ~(4'b0001 << r_digit);
        r_seg <= w_seg;
      end
      r_load_ack   <= w_frame_end && r_pending;
      r_frame_done <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign dp         = 1'b1;
  assign load_ack   = r_load_ack;
  assign frame_done = r_frame_done;

endmodule
